// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU load/store path and debug/loader) for the single data memory port.
// Each access runs IDLE (issue) -> WAIT (capture) -> DONE (ack); the CPU has priority unless debug is starved.
module dmem_arbiter #(
  parameter int DBITS      = 32,
  parameter int ABITS      = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [ABITS-1:0] cpu_addr,
  input  logic [DBITS-1:0] cpu_din,
  output logic [DBITS-1:0] cpu_dout,
  output logic             cpu_ack,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [ABITS-1:0] dbg_addr,
  input  logic [DBITS-1:0] dbg_din,
  output logic [DBITS-1:0] dbg_dout,
  output logic             dbg_ack,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_din,
  input  logic [DBITS-1:0] mem_dout,
  output logic             stall,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     r_state;
  logic       r_owner;   // 1 = debug owns the in-flight access
  logic       r_rd;      // in-flight access is a read
  logic [3:0] r_starve;  // CPU grants taken while debug was waiting

  logic w_dbg_win;
  logic w_issue;
  logic w_we;

  // Debug wins outright when alone, or when it has waited out STARVE_MAX CPU grants.
  assign w_dbg_win = dbg_req & ((r_starve >= STARVE_LIM) | ~cpu_req);
  // Reset gates the issue so a request held through reset can never commit a write.
  assign w_issue   = (r_state == S_IDLE) & ~rst & (cpu_req | dbg_req);
  assign w_we      = w_dbg_win ? dbg_we : cpu_we;

  assign mem_en   = w_issue;
  assign mem_we   = w_issue & w_we;
  assign mem_addr = w_dbg_win ? dbg_addr : cpu_addr;
  assign mem_din  = w_dbg_win ? dbg_din  : cpu_din;

  assign stall = cpu_req & ~cpu_ack;
  assign busy  = (r_state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments only; the ack defaults to 0 each
  // cycle so it is a single-cycle pulse without extra clear logic in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_rd     <= 1'b0;
      r_starve <= '0;
      cpu_dout <= '0;
      dbg_dout <= '0;
      cpu_ack  <= 1'b0;
      dbg_ack  <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            r_owner <= w_dbg_win;
            r_rd    <= ~w_we;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_rd) begin
            if (r_owner) dbg_dout <= mem_dout;
            else         cpu_dout <= mem_dout;
          end
          if (r_owner) dbg_ack <= 1'b1;
          else         cpu_ack <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (!dbg_req) begin
        r_starve <= '0;
      end else if (w_issue) begin
        if (w_dbg_win)                 r_starve <= '0;
        else if (r_starve < STARVE_LIM) r_starve <= r_starve + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a transaction-level model with its own shadow memory.
module tb_dmem_arbiter;

  localparam int DBITS      = 32;
  localparam int ABITS      = 32;
  localparam int STARVE_MAX = 4;

  logic             clk;
  logic             rst;
  logic             cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ABITS-1:0] cpu_addr, dbg_addr;
  logic [DBITS-1:0] cpu_din, dbg_din;
  logic [DBITS-1:0] cpu_dout, dbg_dout;
  logic             cpu_ack, dbg_ack;
  logic             mem_en, mem_we;
  logic [ABITS-1:0] mem_addr;
  logic [DBITS-1:0] mem_din, mem_dout;
  logic             stall, busy;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter #(.DBITS(DBITS), .ABITS(ABITS), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_din(dbg_din),
    .dbg_dout(dbg_dout), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall(stall), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int a);
    return 32'h5A00_0000 + 32'(a) * 32'h0001_0101;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Data memory: registered read, write commits on the enable edge.
  logic [DBITS-1:0] phys [256];
  initial begin
    for (int i = 0; i < 256; i++) phys[i] = init_word(i);
    phys[8'h10] = 32'hDEAD_BEEF;
    mem_dout = '0;
    forever begin
      @(posedge clk);
      if (mem_en === 1'b1) begin
        if (mem_we) phys[mem_addr[7:0]] <= mem_din;
        else        mem_dout <= phys[mem_addr[7:0]];
      end
    end
  end

  // Reference model: one access per three cycles, result due two cycles after issue.
  typedef struct {
    int          t;
    bit          dbg;
    bit          rd;
    logic [31:0] data;
  } pend_t;

  initial begin : model
    logic [31:0] shadow [256];
    pend_t       pend [$];
    pend_t       p;
    int          cyc, last_issue, starve;
    bit          valid, issue, win_dbg, e_cpu_ack, e_dbg_ack, e_we;
    logic [31:0] m_cpu_dout, m_dbg_dout, e_addr, e_din;
    for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    shadow[8'h10] = 32'hDEAD_BEEF;
    valid = 0; cyc = 0; last_issue = -1000; starve = 0;
    m_cpu_dout = '0; m_dbg_dout = '0;
    forever begin
      @(negedge clk);
      if (valid) begin
        e_cpu_ack = 0;
        e_dbg_ack = 0;
        if (pend.size() > 0 && pend[0].t == cyc) begin
          p = pend.pop_front();
          if (p.dbg) begin
            e_dbg_ack = 1;
            if (p.rd) m_dbg_dout = p.data;
          end else begin
            e_cpu_ack = 1;
            if (p.rd) m_cpu_dout = p.data;
          end
        end
        issue   = !rst && (cyc - last_issue >= 3) && (cpu_req || dbg_req);
        win_dbg = dbg_req && (starve >= STARVE_MAX || !cpu_req);
        e_we    = win_dbg ? dbg_we : cpu_we;
        e_addr  = win_dbg ? dbg_addr : cpu_addr;
        e_din   = win_dbg ? dbg_din : cpu_din;

        check("mem_en", 64'(mem_en), 64'(issue));
        check("mem_we", 64'(mem_we), 64'(issue && e_we));
        if (issue) begin
          check("mem_addr", 64'(mem_addr), 64'(e_addr));
          check("mem_din", 64'(mem_din), 64'(e_din));
        end
        check("cpu_ack", 64'(cpu_ack), 64'(e_cpu_ack));
        check("dbg_ack", 64'(dbg_ack), 64'(e_dbg_ack));
        check("cpu_dout", 64'(cpu_dout), 64'(m_cpu_dout));
        check("dbg_dout", 64'(dbg_dout), 64'(m_dbg_dout));
        check("busy", 64'(busy), 64'((cyc - last_issue) inside {1, 2}));
        check("stall", 64'(stall), 64'(cpu_req && !e_cpu_ack));

        if (rst) begin
          pend.delete();
          m_cpu_dout = '0; m_dbg_dout = '0;
          starve = 0; last_issue = -1000;
        end else begin
          if (issue) begin
            p.t    = cyc + 2;
            p.dbg  = win_dbg;
            p.rd   = !e_we;
            p.data = shadow[e_addr[7:0]];
            if (e_we) shadow[e_addr[7:0]] = e_din;
            pend.push_back(p);
            last_issue = cyc;
          end
          if (!dbg_req)   starve = 0;
          else if (issue) starve = win_dbg ? 0 : (starve < STARVE_MAX ? starve + 1 : starve);
        end
      end else if (rst === 1'b1) begin
        valid = 1;
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_din = '0;
  endtask

  task automatic rand_inputs(input int req_pct);
    cpu_req  = ($urandom_range(0, 99) < req_pct);
    dbg_req  = ($urandom_range(0, 99) < req_pct);
    cpu_we   = $urandom_range(0, 1) == 1;
    dbg_we   = $urandom_range(0, 1) == 1;
    cpu_addr = (($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FF00) : 32'h0)
               | 32'($urandom_range(0, 31));
    dbg_addr = (($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FF00) : 32'h0)
               | 32'($urandom_range(0, 31));
    cpu_din  = $urandom();
    dbg_din  = $urandom();
  endtask

  initial begin
    logic en_log [16];
    logic dbg_log [16];

    // Reset held for two cycles under random requests.
    rst = 1;
    rand_inputs(70);
    tick();
    rand_inputs(70);
    @(negedge clk);
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_dbg_ack", 64'(dbg_ack), 64'd0);
    check("rst_cpu_dout", 64'(cpu_dout), 64'd0);
    check("rst_dbg_dout", 64'(dbg_dout), 64'd0);
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    rst = 0;
    idle_all();
    tick();

    // CPU read of 0x10.
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    @(negedge clk);
    check("rd_en", 64'(mem_en), 64'd1);
    check("rd_addr", 64'(mem_addr), 64'h10);
    check("rd_stall0", 64'(stall), 64'd1);
    tick(); @(negedge clk);
    check("rd_stall1", 64'(stall), 64'd1);
    tick(); @(negedge clk);
    check("rd_ack", 64'(cpu_ack), 64'd1);
    check("rd_data", 64'(cpu_dout), 64'hDEAD_BEEF);
    check("rd_stall2", 64'(stall), 64'd0);
    tick();
    idle_all();
    tick();

    // Contention: CPU first, debug issued in cycle 3.
    cpu_req = 1; cpu_addr = 32'h14;
    dbg_req = 1; dbg_addr = 32'h18;
    @(negedge clk);
    check("ct_cpu_issue", 64'(mem_addr), 64'h14);
    tick(); tick(); @(negedge clk);
    check("ct_cpu_ack", 64'(cpu_ack), 64'd1);
    check("ct_dbg_ack2", 64'(dbg_ack), 64'd0);
    tick();
    cpu_req = 0;
    @(negedge clk);
    check("ct_dbg_en", 64'(mem_en), 64'd1);
    check("ct_dbg_issue", 64'(mem_addr), 64'h18);
    tick(); tick(); @(negedge clk);
    check("ct_dbg_ack", 64'(dbg_ack), 64'd1);
    check("ct_dbg_data", 64'(dbg_dout), 64'(init_word(8'h18)));
    tick();
    idle_all();
    tick(); tick();

    // Starvation: both requesters held for 16 cycles.
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h30;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h40;
      @(negedge clk);
      en_log[k]  = mem_en;
      dbg_log[k] = (mem_addr == 32'h40);
    end
    for (int k = 0; k < 16; k++) begin
      check($sformatf("sv_en_%0d", k), 64'(en_log[k]), 64'(k % 3 == 0));
      if (k % 3 == 0) check($sformatf("sv_dbg_%0d", k), 64'(dbg_log[k]), 64'(k == 12));
    end
    tick();
    idle_all();
    repeat (4) tick();

    // Debug write to 0x20, then CPU read of it.
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_din = 32'h1234_5678;
    tick(); tick(); @(negedge clk);
    check("wr_dbg_ack", 64'(dbg_ack), 64'd1);
    check("wr_dbg_dout_hold", 64'(dbg_dout), 64'(init_word(8'h40)));
    tick();
    idle_all();
    cpu_req = 1; cpu_addr = 32'h20;
    tick(); tick(); @(negedge clk);
    check("wr_cpu_ack", 64'(cpu_ack), 64'd1);
    check("wr_cpu_data", 64'(cpu_dout), 64'h1234_5678);
    tick();
    idle_all();
    tick();

    // Debug write, then reset during the WAIT cycle of a CPU read.
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h24; dbg_din = 32'hCAFE_F00D;
    tick(); tick(); tick();
    idle_all();
    cpu_req = 1; cpu_addr = 32'h10;
    tick();
    rst = 1;
    tick();
    rst = 0;
    cpu_req = 0;
    @(negedge clk);
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_cpu_ack0", 64'(cpu_ack), 64'd0);
    tick(); @(negedge clk);
    check("rw_cpu_ack1", 64'(cpu_ack), 64'd0);
    tick();
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h24;
    tick(); tick(); @(negedge clk);
    check("rw_dbg_ack", 64'(dbg_ack), 64'd1);
    check("rw_dbg_data", 64'(dbg_dout), 64'hCAFE_F00D);
    tick();
    idle_all();
    tick();

    // Random traffic with occasional resets; load level changes per epoch.
    for (int e = 0; e < 30; e++) begin
      int pct;
      pct = $urandom_range(20, 100);
      for (int c = 0; c < 100; c++) begin
        tick();
        rst = ($urandom_range(0, 199) == 0);
        rand_inputs(pct);
      end
    end
    tick();
    rst = 0;
    idle_all();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port (data_mem: en/we/addr/din/dout) between two requesters: the stack CPU load/store path and a debug/loader port used to preload or inspect memory.
- Sequences each access through a small FSM, returns read data with a one-cycle ack pulse, and drives a stall to hold the CPU pc register while a CPU access is outstanding.
- Sits between the CPU datapath and data_mem, replacing the direct addr_mem/din_mem wiring.

Parameters:
- DBITS, 32, data width.
- ABITS, 32, address width.
- STARVE_MAX, 4, number of consecutive CPU grants while dbg_req is pending, after which debug wins. Range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- cpu_req  in  1  CPU access request; held with cpu_we/cpu_addr/cpu_din until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ABITS  CPU address.
- cpu_din  in  DBITS  CPU write data.
- cpu_dout  out  DBITS  registered CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- dbg_req, dbg_we, dbg_addr, dbg_din, dbg_dout, dbg_ack: same roles and widths as the cpu_* ports, for the debug/loader requester.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ABITS  memory address.
- mem_din  out  DBITS  memory write data.
- mem_dout  in  DBITS  memory read data; valid the cycle after mem_en=1 with mem_we=0.
- stall  out  1  combinational: cpu_req & ~cpu_ack.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (synchronous): FSM goes to IDLE. These are 0 after reset: cpu_dout, dbg_dout, cpu_ack, dbg_ack, mem_en, mem_we, the owner register and starve_cnt.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Arbitrate combinationally.
  - Drive the winner's en/we/addr/din to memory in the same cycle.
  - Latch the owner and go to WAIT.
  - With no request, mem_en=0 and the FSM stays in IDLE.
- WAIT:
  - mem_en=0 and mem_we=0.
  - For a read, capture mem_dout into the owner's dout register at the end of the cycle.
  - Set the owner's ack and go to DONE.
- DONE:
  - Owner's ack=1 for exactly this cycle.
  - No arbitration in this cycle; go to IDLE.
- Latency: issue in cycle N, ack and dout valid in cycle N+2. Maximum throughput is one access per 3 cycles.
- Writes: memory commits at the end of the issue edge; mem_we is asserted only in the issue cycle. Ack timing is the same as for reads. The owner's dout is unchanged on a write.
- Arbitration:
  - CPU has priority.
  - Exception: when dbg_req=1 and starve_cnt >= STARVE_MAX, debug wins.
  - starve_cnt increments (saturating at STARVE_MAX) on each CPU grant while dbg_req=1.
  - starve_cnt clears on a debug grant, or in any cycle where dbg_req=0.
- Request dropped mid-access: the access still completes and ack still pulses; the arbiter never cancels an issued access.
- Requester reasserts req in its own DONE cycle: it is re-arbitrated in the following IDLE cycle.
- The non-owner's ack is always 0 and its dout holds its value.
- Reset mid-operation: any pending ack is suppressed and the FSM returns to IDLE. A write issued before reset remains committed in memory.
- Address/data from a requester are only sampled in the IDLE issue cycle; later changes before ack have no effect.

Test Plan:
- Reset: rst high for 2 cycles with random requests → all outputs 0, busy=0, mem_en=0 throughout.
- CPU read: mem[0x10]=0xDEADBEEF, cpu_req/cpu_addr=0x10 in cycle 0 → mem_en=1 and mem_addr=0x10 in cycle 0; cpu_ack=1 and cpu_dout=0xDEADBEEF in cycle 2; stall=1 in cycles 0–1 and 0 in cycle 2.
- Contention: cpu_req and dbg_req both asserted in cycle 0 → CPU issued in cycle 0 with cpu_ack in cycle 2; debug issued in cycle 3 with dbg_ack in cycle 5.
- Starvation: cpu_req held continuously, dbg_req held, STARVE_MAX=4 → 4 CPU grants (issue cycles 0, 3, 6, 9), then debug issued in cycle 12 and starve_cnt returns to 0; CPU is granted again in cycle 15.
- Write-then-read: debug write 0x20 ← 0x12345678, then CPU read of 0x20 → cpu_dout=0x12345678; dbg_dout unchanged by the write.
- Reset in WAIT: rst asserted during the WAIT cycle of a CPU read → FSM in IDLE next cycle, cpu_ack never pulses; a debug write issued before the reset reads back correctly afterwards.
